// File: rtl/md_issue_pkg.sv
// md_issue_pkg: MDOp codes, op-class helpers and the queue entry type shared by md_issue.
package md_issue_pkg;
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_entry_t;

    function automatic logic is_start(input logic [3:0] op);
        return op >= MD_MULT && op <= MD_DIVU;
    endfunction

    function automatic logic is_move(input logic [3:0] op);
        return op == MD_MTHI || op == MD_MTLO;
    endfunction

    function automatic logic is_read(input logic [3:0] op);
        return op == MD_MFHI || op == MD_MFLO;
    endfunction
endpackage

// File: rtl/md_issue_fifo.sv
// md_issue_fifo: in-order circular queue of MD ops; DEPTH must be a power of two so pointers wrap naturally.
module md_issue_fifo
    import md_issue_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  md_entry_t       wdata_i,
    output md_entry_t       rdata_o,
    output logic [CW-1:0]   count_o,
    output logic            full_o,
    output logic            empty_o
);
    md_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        head_d  = pop_i ? head_q + 1'b1 : head_q;
        tail_d  = push_i ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        if (push_i) mem_q[tail_q] <= wdata_i;
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
endmodule

// File: rtl/md_issue.sv
// md_issue: E-stage issue controller for the multiply/divide unit, queueing START/MOVE ops and gating mfhi/mflo.
// Defining MD_ISSUE_BYPASS_EN lets a START/MOVE issue in its accept cycle when the queue is empty and the unit idle.
module md_issue
    import md_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        stall,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        md_start,
    output logic [3:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_busy,
    input  logic [31:0] md_out
);
    localparam int CW = $clog2(DEPTH) + 1;

    md_entry_t       head;
    logic [CW-1:0]   count;
    logic            full, empty, disp, sm, rd, take, byp, push, rd_ok;

    md_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (disp),
        .wdata_i ({op, op_a, op_b}),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        disp  = !empty && !md_busy;
        sm    = op_valid && (is_start(op) || is_move(op));
        rd    = op_valid && is_read(op);
        take  = sm && (!full || disp);
`ifdef MD_ISSUE_BYPASS_EN
        byp   = take && empty && !md_busy;
`else
        byp   = 1'b0;
`endif
        push  = take && !byp;
        // reads wait for a drained queue and an idle unit so HI/LO are never stale
        rd_ok = rd && empty && !md_busy;
        stall = (sm && !take) || (rd && !rd_ok);
        rd_valid = rd_ok;
        rd_data  = rd_ok ? md_out : '0;
        md_op    = disp ? head.op : (byp || rd_ok) ? op : MD_NONE;
        md_start = disp ? is_start(head.op) : byp && is_start(op);
        md_a     = disp ? head.a : byp ? op_a : '0;
        md_b     = disp ? head.b : byp ? op_b : '0;
    end
endmodule

// File: tb/tb_md_issue.sv
// tb_md_issue: directed bench for md_issue with a behavioural MD unit and dispatch/read-data scoreboards.
module tb_md_issue;
    import md_issue_pkg::*;

`ifdef MD_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, op_valid = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        stall, rd_valid, md_start, md_busy;
    logic [31:0] rd_data, md_a, md_b, md_out;
    logic [3:0]  md_op;

    int ncmp = 0, nerr = 0, cyc = 0, s;
    md_entry_t   dq[$];
    logic [31:0] rdq[$];
    int          st_cyc[$];

    logic [2:0]  busy_cnt;
    logic [31:0] hi, lo;
    logic [63:0] res_q;

    md_issue #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_a(op_a), .op_b(op_b),
        .stall(stall), .rd_valid(rd_valid), .rd_data(rd_data), .md_start(md_start),
        .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_busy(md_busy), .md_out(md_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] md_calc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (o)
            MD_MULT:  return sa * sb;
            MD_MULTU: return {32'b0, a} * {32'b0, b};
            MD_DIV:   return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            default:  return {a % b, a / b};
        endcase
    endfunction

    // behavioural MD unit: busy for three cycles after a start, result lands as busy falls
    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= '0;
            hi <= '0;
            lo <= '0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1'b1;
            if (busy_cnt == 1) {hi, lo} <= res_q;
        end else if (md_start) begin
            busy_cnt <= 3'd3;
            res_q <= md_calc(md_op, md_a, md_b);
        end else if (md_op == MD_MTHI) hi <= md_a;
        else if (md_op == MD_MTLO) lo <= md_a;
    end
    assign md_busy = busy_cnt != 0;
    assign md_out  = (md_op == MD_MFHI) ? hi : lo;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (!reset) begin
        if ((md_op >= 4'd1 && md_op <= 4'd4) || md_op == MD_MTHI || md_op == MD_MTLO) begin
            if (dq.size() == 0) chk("unexpected_dispatch", md_op, 0);
            else begin
                chk("disp_op", md_op, dq[0].op);
                chk("disp_a", md_a, dq[0].a);
                chk("disp_b", md_b, dq[0].b);
                chk("disp_start", md_start, dq[0].op <= 4'd4);
                if (md_start) st_cyc.push_back(cyc);
                void'(dq.pop_front());
            end
        end
        if (rd_valid) begin
            if (rdq.size() == 0) chk("unexpected_read", rd_valid, 0);
            else begin
                chk("rd_data", rd_data, rdq[0]);
                void'(rdq.pop_front());
            end
        end
    end

    // called at posedge+1; returns at the next posedge+1 after the op is accepted
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_rd, output int stalls);
        stalls = 0;
        op_valid = 1'b1; op = o; op_a = a; op_b = b;
        #1;
        while (stall && stalls < 50) begin
            @(posedge clk); #2;
            stalls++;
        end
        if (stall) chk("accept_timeout", stall, 0);
        else if (o == MD_MFHI || o == MD_MFLO) begin
            chk("rd_valid", rd_valid, 1);
            rdq.push_back(exp_rd);
        end else if (o >= 4'd1 && o <= 4'd8) dq.push_back({o, a, b});
        @(posedge clk); #1;
        op_valid = 1'b0; op = '0; op_a = '0; op_b = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_count", dut.count, 0);
        chk("rst_md_start", md_start, 0);
        chk("rst_md_op", md_op, 0);
        chk("rst_md_ab", {md_a, md_b}, 0);
        chk("rst_rd", {rd_valid, rd_data}, 0);
        chk("rst_stall", stall, 0);

        issue(MD_MULT, 32'd3, 32'hFFFF_FFFE, 0, s);
        chk("mult_stall", s, 0);
        issue(MD_MFLO, 0, 0, 32'hFFFF_FFFA, s);
        chk("mflo_wait", s, BYP ? 3 : 4);
        issue(MD_MFHI, 0, 0, 32'hFFFF_FFFF, s);
        chk("mfhi_nowait", s, 0);

        op_valid = 1'b1; op = 4'd9; #1;
        chk("none_stall", stall, 0);
        chk("none_md_op", md_op, 0);
        chk("none_start", md_start, 0);
        @(posedge clk); #1 op_valid = 1'b0; op = '0;

        idle(4);
        st_cyc.delete();
        issue(MD_MULT, 32'd5, 32'd6, 0, s);
        chk("b2b_s1", s, 0);
        issue(MD_MULTU, 32'd7, 32'd8, 0, s);
        chk("b2b_s2", s, 0);
        issue(MD_DIV, 32'd100, 32'd7, 0, s);
        chk("b2b_s3", s, 0);
        issue(MD_DIVU, 32'd11, 32'd3, 0, s);
        chk("full_stall", s, BYP ? 1 : 2);
        idle(20);
        chk("b2b_starts", st_cyc.size(), 4);
        if (st_cyc.size() == 4) begin
            chk("gap_12", st_cyc[1] - st_cyc[0], 4);
            chk("gap_23", st_cyc[2] - st_cyc[1], 4);
            chk("gap_34", st_cyc[3] - st_cyc[2], 4);
        end

        issue(MD_DIVU, 32'd7, 32'd2, 0, s);
        issue(MD_MTHI, 32'h1234, 0, 0, s);
        chk("mthi_accept", s, 0);
        issue(MD_MFHI, 0, 0, 32'h1234, s);
        issue(MD_MFLO, 0, 0, 32'd3, s);

        idle(2);
        issue(MD_MFHI, 0, 0, 32'h1234, s);
        chk("mfhi_idle_stall", s, 0);

        issue(MD_MULT, 32'd1, 32'd1, 0, s);
        issue(MD_MULT, 32'd2, 32'd2, 0, s);
        issue(MD_MULT, 32'd3, 32'd3, 0, s);
        chk("pre_rst_count", dut.count, 2);
        chk("pre_rst_busy", md_busy, 1);
        reset = 1'b1;
        dq.delete();
        @(posedge clk); #1 reset = 1'b0;
        chk("post_rst_count", dut.count, 0);
        chk("post_rst_start", md_start, 0);
        chk("post_rst_stall", stall, 0);
        issue(MD_MFHI, 0, 0, 32'd0, s);
        chk("post_rst_rd_wait", s, 0);

        op_valid = 1'b1; op = MD_MULTU; op_a = 32'hFFFF_FFFF; op_b = 32'd2; #1;
        chk("byp_stall", stall, 0);
        chk("byp_start", md_start, BYP);
        dq.push_back({MD_MULTU, 32'hFFFF_FFFF, 32'd2});
        @(posedge clk); #1 op_valid = 1'b0; op = '0; op_a = '0; op_b = '0;
        chk("byp_count", dut.count, BYP ? 0 : 1);
        issue(MD_MFHI, 0, 0, 32'd1, s);
        issue(MD_MFLO, 0, 0, 32'hFFFF_FFFE, s);

        idle(3);
        chk("dq_drained", dq.size(), 0);
        chk("rdq_drained", rdq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
